// File: rtl/sign_pkg.sv
// Shared encodings for the country-road sign controller and its front-end blocks.
// Country-road signal values, the car_detector FSM states and TRUE/FALSE helpers.
`ifndef SIGN_PKG_TRUE_FALSE
`define SIGN_PKG_TRUE_FALSE
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package sign_pkg;
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SERVE = 2'd2,
    HOLD  = 2'd3
  } det_st_e;
endpackage

// File: rtl/car_detector_if.sv
// Request/acknowledge link between car_detector (master) and sign_contr (slave).
// The controller answers a request by driving CNTRY_SIG to GREEN.
interface car_detector_if;
  logic [1:0] CNTRY_SIG;
  logic       CAR_ON_CNTRY_RD;
  logic [7:0] CAR_COUNT;

  modport master (input CNTRY_SIG, output CAR_ON_CNTRY_RD, output CAR_COUNT);
  modport slave  (output CNTRY_SIG, input CAR_ON_CNTRY_RD, input CAR_COUNT);
endinterface

// File: rtl/loop_debounce.sv
// Two-flop synchronizer followed by a debounce filter for a bouncing sensor pin.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module loop_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLOCK,
  input  logic CLEAR_N,
  input  logic i_raw,
  output logic o_loop_db
);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1, r_sync2, r_loop_db;
  logic [3:0] r_cnt;

  // Synchronize the raw pin, then count stable differing samples before accepting them.
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_loop_db <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_loop_db) begin
        if (r_cnt == DB_LAST) begin
          r_loop_db <= r_sync2;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_loop_db = r_loop_db;
endmodule

// File: rtl/car_detector.sv
// Country-road car detector: conditions LOOP_RAW and raises a sticky request to sign_contr.
// Request is held while waiting for GREEN, then for HOLD_CYCLES after the car leaves.
// Optional macro CAR_DETECTOR_COUNT_EN enables the saturating arrival counter on CAR_COUNT.
module car_detector
  import sign_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic                  CLOCK,
  input  logic                  CLEAR_N,
  input  logic                  LOOP_RAW,
  car_detector_if.master        sig_bus
);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);

  logic    w_loop_db, w_rise, w_fall, w_green;
  logic    r_db_q, r_car;
  logic [7:0] r_hold;
  det_st_e r_state;

  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .CLOCK     (CLOCK),
    .CLEAR_N   (CLEAR_N),
    .i_raw     (LOOP_RAW),
    .o_loop_db (w_loop_db)
  );

  // Delayed copy of the debounced level for single-cycle edge strobes.
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) r_db_q <= 1'b0;
    else          r_db_q <= w_loop_db;
  end

  assign w_rise  = w_loop_db & ~r_db_q;
  assign w_fall  = ~w_loop_db & r_db_q;
  // Encoding 3 is illegal and simply falls out as not-GREEN.
  assign w_green = (sig_bus.CNTRY_SIG == GREEN);

  // Request FSM with hold timer; the request output is registered alongside the state.
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_car   <= `FALSE;
    end else begin
      case (r_state)
        IDLE: begin
          // GREEN in the same cycle as the rise is only seen from WAIT next cycle.
          if (w_rise) begin
            r_state <= WAIT;
            r_car   <= `TRUE;
          end
        end
        WAIT: begin
          if (w_green) begin
            if (w_loop_db) begin
              r_state <= SERVE;
            end else begin
              r_state <= HOLD;
              r_hold  <= HOLD_LD;
            end
          end
        end
        SERVE: begin
          if (w_fall) begin
            r_state <= HOLD;
            r_hold  <= HOLD_LD;
          end
        end
        HOLD: begin
          if (w_rise) begin
            r_state <= w_green ? SERVE : WAIT;
          end else if (r_hold == 8'd0) begin
            r_state <= IDLE;
            r_car   <= `FALSE;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_car   <= `FALSE;
        end
      endcase
    end
  end

  assign sig_bus.CAR_ON_CNTRY_RD = r_car;

`ifdef CAR_DETECTOR_COUNT_EN
  logic [7:0] r_count;

  // Saturating count of accepted arrivals, in any FSM state.
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N)                       r_count <= '0;
    else if (w_rise && r_count != 8'hFF) r_count <= r_count + 8'd1;
  end

  assign sig_bus.CAR_COUNT = r_count;
`else
  assign sig_bus.CAR_COUNT = 8'h00;
`endif
endmodule

// File: tb/tb_car_detector.sv
// Directed bench for car_detector (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, 10 ns clock).
// Expected arrival count follows CAR_DETECTOR_COUNT_EN; it is 0 when the macro is absent.
module tb_car_detector;
  import sign_pkg::*;

  logic CLOCK = 1'b0;
  logic CLEAR_N;
  logic LOOP_RAW;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  car_detector_if bus();

  car_detector #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .CLOCK   (CLOCK),
    .CLEAR_N (CLEAR_N),
    .LOOP_RAW(LOOP_RAW),
    .sig_bus (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic bump();
    if (exp_cnt != 255) exp_cnt++;
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef CAR_DETECTOR_COUNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    CLEAR_N = 1'b0;
    LOOP_RAW = 1'b0;
    bus.CNTRY_SIG = RED;
    repeat (3) tick();
    chk("rst_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    chk("rst_cnt", 32'(bus.CAR_COUNT), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    CLEAR_N = 1'b1;
    repeat (2) tick();

    // Arrival on RED: 7-edge latency, then held for 200 cycles.
    LOOP_RAW = 1'b1;
    repeat (6) tick();
    chk("lat_pre", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    tick();
    chk("lat_edge7", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    bump();
    chk("arr_cnt", 32'(bus.CAR_COUNT), cnt_exp());
    repeat (200) tick();
    chk("hold_red", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    chk("wait_state", 32'(dut.r_state), 32'(WAIT));

    // Serve and hold: fall accepted at edge 6, HOLD at 7, drop at 15.
    bus.CNTRY_SIG = GREEN;
    tick();
    chk("serve_state", 32'(dut.r_state), 32'(SERVE));
    LOOP_RAW = 1'b0;
    repeat (14) tick();
    chk("hold_last", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    chk("hold_state", 32'(dut.r_state), 32'(HOLD));
    tick();
    chk("hold_drop", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    chk("hold_idle", 32'(dut.r_state), 32'(IDLE));

    // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
    bus.CNTRY_SIG = RED;
    LOOP_RAW = 1'b1;
    repeat (3) tick();
    LOOP_RAW = 1'b0;
    repeat (12) tick();
    chk("glitch3_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    chk("glitch3_cnt", 32'(bus.CAR_COUNT), cnt_exp());
    LOOP_RAW = 1'b1;
    repeat (4) tick();
    LOOP_RAW = 1'b0;
    repeat (3) tick();
    chk("pulse4_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    bump();
    chk("pulse4_cnt", 32'(bus.CAR_COUNT), cnt_exp());
    repeat (20) tick();
    chk("sticky_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    chk("sticky_state", 32'(dut.r_state), 32'(WAIT));

    // Sticky request: car already gone when GREEN arrives, straight to HOLD.
    bus.CNTRY_SIG = GREEN;
    repeat (8) tick();
    chk("sticky_hold", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    tick();
    chk("sticky_drop", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    chk("sticky_idle", 32'(dut.r_state), 32'(IDLE));

    // Re-trigger in HOLD while GREEN: request never drops.
    LOOP_RAW = 1'b1;
    repeat (7) tick();
    chk("retrig_req", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    bump();
    tick();
    chk("retrig_serve", 32'(dut.r_state), 32'(SERVE));
    LOOP_RAW = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("retrig_hi_a", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    end
    LOOP_RAW = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("retrig_hi_b", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    end
    bump();
    chk("retrig_cnt", 32'(bus.CAR_COUNT), cnt_exp());
    chk("retrig_state", 32'(dut.r_state), 32'(SERVE));
    LOOP_RAW = 1'b0;
    repeat (20) tick();
    chk("retrig_end", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);

    // Mid-cycle asynchronous reset with the car present.
    bus.CNTRY_SIG = RED;
    LOOP_RAW = 1'b1;
    repeat (10) tick();
    chk("pre_rst_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    #3;
    CLEAR_N = 1'b0;
    exp_cnt = 0;
    #1;
    chk("arst_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    chk("arst_cnt", 32'(bus.CAR_COUNT), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_hold", 32'({bus.CAR_ON_CNTRY_RD, bus.CAR_COUNT}), 32'd0);
    end
    CLEAR_N = 1'b1;
    repeat (6) tick();
    chk("rel_pre", 32'(bus.CAR_ON_CNTRY_RD), 32'd0);
    tick();
    chk("rel_req", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);
    bump();
    chk("rel_cnt", 32'(bus.CAR_COUNT), cnt_exp());

    // Saturation: 300 more accepted arrivals on RED.
    for (int i = 0; i < 300; i++) begin
      LOOP_RAW = 1'b0;
      repeat (8) tick();
      LOOP_RAW = 1'b1;
      repeat (8) tick();
      bump();
      if (i == 100) chk("sat_mid", 32'(bus.CAR_COUNT), cnt_exp());
    end
    chk("sat_cnt", 32'(bus.CAR_COUNT), cnt_exp());
    chk("sat_car", 32'(bus.CAR_ON_CNTRY_RD), 32'd1);

    // Illegal signal encoding is not GREEN; real GREEN then serves.
    bus.CNTRY_SIG = 2'd3;
    repeat (20) tick();
    chk("ill_state", 32'(dut.r_state), 32'(WAIT));
    bus.CNTRY_SIG = GREEN;
    tick();
    chk("ill_green", 32'(dut.r_state), 32'(SERVE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
